// File: rtl/vga_mem_writer.sv
// vga_mem_writer
// Write-side port controller for the shared 1024x16 VGA glyph/score memory.
// Processor writes arrive through a valid/ready handshake and are queued in a
// small FIFO. Block-fill commands clear or paint an address range. The memory
// write port is driven one word per cycle.
//
// Optional feature macro: BLANK_ONLY_WRITE_EN
//   defined   -> writes are issued only while bright==0 (blanking interval)
//   undefined -> writes are issued every cycle and bright is ignored
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready     write request handshake (req_addr, req_data)
//   fill_start              one-cycle fill strobe (fill_base, fill_count, fill_data)
//   fill_busy, fill_done    fill in progress / one-cycle completion pulse
//   bright                  active-display flag from the timing generator
//   MemEnA, MemWEnA,
//   MemAddrA, MemDataA      memory write port (all zero when no write issues)
//   fifo_level              current request FIFO occupancy
module vga_mem_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_data,
    input  logic                          fill_start,
    input  logic [ADDR_W-1:0]             fill_base,
    input  logic [ADDR_W:0]               fill_count,
    input  logic [DATA_W-1:0]             fill_data,
    output logic                          fill_busy,
    output logic                          fill_done,
    input  logic                          bright,
    output logic                          MemEnA,
    output logic                          MemWEnA,
    output logic [ADDR_W-1:0]             MemAddrA,
    output logic [DATA_W-1:0]             MemDataA,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    // Request FIFO storage: small enough to live in registers, read
    // combinationally so a request can reach the memory the cycle after it
    // is accepted.
    logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [LVL_W-1:0]    w_level_next;

    // Fill descriptor
    logic                r_fill_busy;
    logic                r_fill_pending;
    logic                r_fill_done;
    logic [ADDR_W-1:0]   r_fill_addr;
    logic [ADDR_W:0]     r_fill_remaining;
    logic [DATA_W-1:0]   r_fill_data;

    logic                w_write_ok;
    logic                w_fifo_empty;
    logic                w_ready;
    logic                w_push;
    logic                w_pop;
    logic                w_fill_wr;
    logic                w_fill_last;
    logic                w_fill_accept;
    logic                w_enter_fill;

`ifdef BLANK_ONLY_WRITE_EN
    // Writes only during blanking so a glyph never tears mid-frame.
    assign w_write_ok = !bright;
`else
    logic w_unused_bright;
    assign w_unused_bright = bright;
    assign w_write_ok      = 1'b1;
`endif

    assign w_fifo_empty  = (r_level == '0);
    assign w_ready       = !reset && (r_level < LVL_W'(FIFO_DEPTH)) && !r_fill_busy;
    assign w_push        = req_valid && w_ready;
    // Queued requests drain in IDLE as well as DRAIN so a request reaches
    // the memory port the cycle after acceptance.
    assign w_pop         = !reset && (r_state != FILL) && !w_fifo_empty && w_write_ok;
    assign w_fill_wr     = !reset && (r_state == FILL) && w_write_ok;
    assign w_fill_last   = w_fill_wr && (r_fill_remaining == (ADDR_W+1)'(1));
    assign w_fill_accept = !reset && fill_start && !r_fill_busy;
    assign w_enter_fill  = (r_state != FILL) && (w_state_next == FILL);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_fill_pending && w_fifo_empty) begin
                    w_state_next = FILL;
                end else if (!w_fifo_empty) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_fifo_empty) begin
                    w_state_next = r_fill_pending ? FILL : IDLE;
                end
            end
            FILL: begin
                if (w_fill_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + LVL_W'(1);
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= req_addr;
            r_fifo_data[r_wr_ptr] <= req_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= IDLE;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_level          <= '0;
            r_fill_busy      <= 1'b0;
            r_fill_pending   <= 1'b0;
            r_fill_done      <= 1'b0;
            r_fill_addr      <= '0;
            r_fill_remaining <= '0;
            r_fill_data      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_level     <= w_level_next;
            r_fill_done <= 1'b0;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_fill_accept) begin
                if (fill_count == '0) begin
                    // Empty fill: nothing to write, complete immediately.
                    r_fill_done <= 1'b1;
                end else begin
                    r_fill_busy      <= 1'b1;
                    r_fill_pending   <= 1'b1;
                    r_fill_addr      <= fill_base;
                    r_fill_remaining <= fill_count;
                    r_fill_data      <= fill_data;
                end
            end
            if (w_enter_fill) begin
                r_fill_pending <= 1'b0;
            end
            if (w_fill_wr) begin
                // Address wraps naturally at 2^ADDR_W.
                r_fill_addr      <= r_fill_addr + ADDR_W'(1);
                r_fill_remaining <= r_fill_remaining - (ADDR_W+1)'(1);
                if (w_fill_last) begin
                    r_fill_busy <= 1'b0;
                    r_fill_done <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        MemEnA   = w_pop || w_fill_wr;
        MemWEnA  = w_pop || w_fill_wr;
        MemAddrA = '0;
        MemDataA = '0;
        if (w_fill_wr) begin
            MemAddrA = r_fill_addr;
            MemDataA = r_fill_data;
        end else if (w_pop) begin
            MemAddrA = r_fifo_addr[r_rd_ptr];
            MemDataA = r_fifo_data[r_rd_ptr];
        end
    end

    // Status outputs read as zero for as long as reset is held.
    assign req_ready  = w_ready;
    assign fill_busy  = r_fill_busy && !reset;
    assign fill_done  = r_fill_done && !reset;
    assign fifo_level = reset ? '0 : r_level;

endmodule

// File: tb/tb_vga_mem_writer.sv
// Testbench for vga_mem_writer: directed scenarios followed by randomized
// traffic, all checked every cycle against a queue-based behavioural model.
module tb_vga_mem_writer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_addr;
    logic [15:0] req_data;
    logic        fill_start;
    logic [9:0]  fill_base;
    logic [10:0] fill_count;
    logic [15:0] fill_data;
    logic        fill_busy;
    logic        fill_done;
    logic        bright;
    logic        MemEnA;
    logic        MemWEnA;
    logic [9:0]  MemAddrA;
    logic [15:0] MemDataA;
    logic [2:0]  fifo_level;

    always #20 clock = ~clock;

    vga_mem_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(10), .DATA_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_count (fill_count),
        .fill_data  (fill_data),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .bright     (bright),
        .MemEnA     (MemEnA),
        .MemWEnA    (MemWEnA),
        .MemAddrA   (MemAddrA),
        .MemDataA   (MemDataA),
        .fifo_level (fifo_level)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {logic [9:0] a; logic [15:0] d;} req_t;
    typedef struct {int a; int d; int c;} wr_t;

    req_t        mq[$];
    bit          m_busy = 0, m_pend = 0, m_active = 0, m_done = 0;
    logic [9:0]  m_faddr = '0;
    int          m_frem = 0;
    logic [15:0] m_fdata = '0;

    wr_t wlog[$];
    int  done_cnt = 0;
    int  done_cyc = -1;

    always @(negedge clock) begin
        logic        w_ok, fill_wr, fifo_wr, s_empty, s_pend, s_busy;
        logic        e_ready, e_busy, e_done, e_we;
        logic [2:0]  e_level;
        logic [9:0]  e_addr;
        logic [15:0] e_data;
`ifdef BLANK_ONLY_WRITE_EN
        w_ok = !bright;
`else
        w_ok = 1'b1;
`endif
        e_ready = 0; e_busy = 0; e_done = 0; e_we = 0;
        e_level = '0; e_addr = '0; e_data = '0;
        fill_wr = 0; fifo_wr = 0;
        if (!reset) begin
            e_ready = (mq.size() < DEPTH) && !m_busy;
            e_level = 3'(mq.size());
            e_busy  = m_busy;
            e_done  = m_done;
            fill_wr = m_active && w_ok;
            fifo_wr = !m_active && (mq.size() > 0) && w_ok;
            if (fill_wr) begin
                e_we = 1; e_addr = m_faddr; e_data = m_fdata;
            end else if (fifo_wr) begin
                e_we = 1; e_addr = mq[0].a; e_data = mq[0].d;
            end
        end
        if (chk_en) begin
            chk("req_ready",  int'(req_ready),  int'(e_ready));
            chk("fifo_level", int'(fifo_level), int'(e_level));
            chk("fill_busy",  int'(fill_busy),  int'(e_busy));
            chk("fill_done",  int'(fill_done),  int'(e_done));
            chk("MemEnA",     int'(MemEnA),     int'(e_we));
            chk("MemWEnA",    int'(MemWEnA),    int'(e_we));
            chk("MemAddrA",   int'(MemAddrA),   int'(e_addr));
            chk("MemDataA",   int'(MemDataA),   int'(e_data));
        end
        if (MemWEnA) begin
            wlog.push_back('{a: int'(MemAddrA), d: int'(MemDataA), c: cyc});
            $display("write cycle=%0d addr=%03h data=%04h", cyc, MemAddrA, MemDataA);
        end
        if (fill_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        // advance model to the next cycle
        if (reset) begin
            mq.delete();
            m_busy = 0; m_pend = 0; m_active = 0; m_done = 0;
        end else begin
            s_empty = (mq.size() == 0);
            s_pend  = m_pend;
            s_busy  = m_busy;
            m_done  = 0;
            if (fill_wr) begin
                m_faddr = m_faddr + 10'd1;
                m_frem--;
                if (m_frem == 0) begin
                    m_active = 0; m_busy = 0; m_done = 1;
                end
            end else if (fifo_wr) begin
                void'(mq.pop_front());
            end
            if (fill_start && !s_busy) begin
                if (fill_count == 0) begin
                    m_done = 1;
                end else begin
                    m_busy = 1; m_pend = 1;
                    m_faddr = fill_base; m_frem = int'(fill_count); m_fdata = fill_data;
                end
            end
            if (req_valid && e_ready) mq.push_back({req_addr, req_data});
            if (s_pend && s_empty) begin
                m_active = 1; m_pend = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_req(input logic [9:0] a, input logic [15:0] d);
        int k = 0;
        req_valid = 1; req_addr = a; req_data = d;
        while (!req_ready && k < 200) begin
            tick();
            k++;
        end
        if (k == 200) begin
            n_cmp++; n_err++;
            $display("FAIL push_timeout: addr %03h not accepted within 200 cycles", a);
        end
        tick();
        req_valid = 0;
    endtask

    task automatic fill_cmd(input logic [9:0] b, input logic [10:0] n, input logic [15:0] d);
        fill_start = 1; fill_base = b; fill_count = n; fill_data = d;
        tick();
        fill_start = 0;
    endtask

    task automatic wait_done(input int prev, input int lim, input string nm);
        int k = 0;
        while (done_cnt == prev && k < lim) begin
            tick();
            k++;
        end
        n_cmp++;
        if (done_cnt == prev) begin
            n_err++;
            $display("FAIL %s: fill_done not seen within %0d cycles", nm, lim);
        end
    endtask

    function automatic int log_a(input int i);
        return (i < wlog.size()) ? wlog[i].a : -1;
    endfunction

    function automatic int log_d(input int i);
        return (i < wlog.size()) ? wlog[i].d : -1;
    endfunction

    function automatic int log_c(input int i);
        return (i < wlog.size()) ? wlog[i].c : -1;
    endfunction

    initial begin
        int c0, d0, d1, k, uniq;
        int exp_a[6];
        bit seen[1024];

        reset = 1; req_valid = 0; req_addr = '0; req_data = '0;
        fill_start = 0; fill_base = '0; fill_count = '0; fill_data = '0; bright = 0;
        tick();
        chk_en = 1;
        tick(); tick();
        chk("ready_in_reset", int'(req_ready), 0);
        reset = 0;
        #1;
        chk("level_after_reset", int'(fifo_level), 0);
        chk("ready_after_reset", int'(req_ready), 1);

        // single write, one-cycle latency
        wlog.delete();
        c0 = cyc;
        push_req(10'h005, 16'hABCD);
        repeat (3) tick();
        chk("single_count", wlog.size(), 1);
        chk("single_addr", log_a(0), 'h005);
        chk("single_data", log_d(0), 'hABCD);
        chk("single_latency", log_c(0), c0 + 1);
        chk("single_level", int'(fifo_level), 0);

        // six requests, stalled while active video when writes are gated
        wlog.delete();
`ifdef BLANK_ONLY_WRITE_EN
        bright = 1;
        for (int i = 0; i < 4; i++) push_req(10'(32'h20 + i), 16'(32'h1000 + i));
        chk("stall_level", int'(fifo_level), 4);
        chk("stall_ready", int'(req_ready), 0);
        req_valid = 1; req_addr = 10'h024; req_data = 16'h1004;
        repeat (3) tick();
        bright = 0;
        push_req(10'h024, 16'h1004);
        push_req(10'h025, 16'h1005);
        repeat (6) tick();
        chk("stall_burst", log_c(3) - log_c(0), 3);
`else
        for (int i = 0; i < 6; i++) push_req(10'(32'h20 + i), 16'(32'h1000 + i));
        repeat (6) tick();
`endif
        chk("six_count", wlog.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("six_addr", log_a(i), 'h20 + i);
            chk("six_data", log_d(i), 'h1000 + i);
        end

        // wrapping fill
        wlog.delete();
        d0 = done_cnt;
        fill_cmd(10'd1022, 11'd4, 16'h0000);
        wait_done(d0, 100, "wrap_done");
        tick();
        exp_a[0] = 1022; exp_a[1] = 1023; exp_a[2] = 0; exp_a[3] = 1;
        chk("wrap_count", wlog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_addr", log_a(i), exp_a[i]);
            chk("wrap_data", log_d(i), 0);
        end
        chk("wrap_consecutive", log_c(3) - log_c(0), 3);
        chk("wrap_done_cycle", done_cyc, log_c(3) + 1);

        // queued requests drain before the fill; requests blocked until done
        wlog.delete();
        d0 = done_cnt;
        push_req(10'h030, 16'h3333);
        fill_start = 1; fill_base = 10'd100; fill_count = 11'd3; fill_data = 16'h1234;
        push_req(10'h031, 16'h4444);
        fill_start = 0;
        chk("order_ready_busy", int'(req_ready), 0);
        req_valid = 1; req_addr = 10'h3FF; req_data = 16'h5555;
        wait_done(d0, 100, "order_done");
        req_valid = 0;
        repeat (3) tick();
        exp_a[0] = 'h30; exp_a[1] = 'h31; exp_a[2] = 100; exp_a[3] = 101;
        exp_a[4] = 102; exp_a[5] = 'h3FF;
        chk("order_count", wlog.size(), 6);
        for (int i = 0; i < 6; i++) chk("order_addr", log_a(i), exp_a[i]);

        // zero-length fill
        wlog.delete();
        d0 = done_cnt;
        c0 = cyc;
        fill_cmd(10'd7, 11'd0, 16'hFFFF);
        repeat (3) tick();
        chk("zero_writes", wlog.size(), 0);
        chk("zero_done_cycle", done_cyc, c0 + 1);
        chk("zero_done_count", done_cnt - d0, 1);

        // second fill_start while busy is ignored
        wlog.delete();
        d1 = done_cnt;
        fill_cmd(10'd200, 11'd5, 16'h00C8);
        tick();
        fill_cmd(10'd300, 11'd7, 16'h0DEF);
        wait_done(d1, 100, "busy_done");
        repeat (12) tick();
        chk("busy_count", wlog.size(), 5);
        chk("busy_done_count", done_cnt - d1, 1);
        for (int i = 0; i < 5; i++) begin
            chk("busy_addr", log_a(i), 200 + i);
            chk("busy_data", log_d(i), 'h00C8);
        end

        // full-memory fill
        wlog.delete();
        d0 = done_cnt;
        fill_cmd(10'd512, 11'd1024, 16'h5A5A);
        wait_done(d0, 1200, "full_done");
        tick();
        for (int i = 0; i < 1024; i++) seen[i] = 0;
        uniq = 0;
        for (int i = 0; i < wlog.size(); i++) begin
            if (wlog[i].a >= 0 && wlog[i].a < 1024 && !seen[wlog[i].a]) begin
                seen[wlog[i].a] = 1;
                uniq++;
            end
        end
        chk("full_count", wlog.size(), 1024);
        chk("full_unique", uniq, 1024);
        chk("full_first", log_a(0), 512);
        chk("full_last", log_a(1023), 511);

        // reset during the third word of a 10-word fill
        wlog.delete();
        d0 = done_cnt;
        fill_cmd(10'd40, 11'd10, 16'hBEEF);
        k = 0;
        while (wlog.size() < 2 && k < 50) begin
            tick();
            k++;
        end
        chk("rst_pre_writes", wlog.size(), 2);
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("rst_we", int'(MemWEnA), 0);
        chk("rst_en", int'(MemEnA), 0);
        chk("rst_addr", int'(MemAddrA), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_busy", int'(fill_busy), 0);
        chk("rst_done", int'(fill_done), 0);
        repeat (20) tick();
        chk("rst_no_more_writes", wlog.size(), 2);
        chk("rst_no_done", done_cnt - d0, 0);

        // randomized traffic
        repeat (3000) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_addr   = 10'($urandom);
            req_data   = 16'($urandom);
            fill_start = ($urandom_range(0, 99) < 3);
            fill_count = ($urandom_range(0, 9) == 0) ? 11'd0 : 11'($urandom_range(1, 12));
            fill_base  = 10'($urandom);
            fill_data  = 16'($urandom);
            bright     = ($urandom_range(0, 9) < 3);
            reset      = ($urandom_range(0, 999) < 3);
            tick();
        end
        req_valid = 0; fill_start = 0; reset = 0; bright = 0;
        repeat (30) tick();
        chk("final_level", int'(fifo_level), 0);
        chk("final_busy", int'(fill_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
